// File: rtl/adder_pkg.sv
// Shared constants for the chunked pipelined adder: mode encoding and chunk sizing.
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int chunk_w(input int n, input int stages);
    return n / stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the pipelined adder: chunk add, registered carry,
// stage valid bit and the elastic advance term.
module adder_stage #(
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic         dn_adv,
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         c_in,
  output logic [C-1:0] s,
  output logic         c_out,
  output logic         vld,
  output logic         adv
);

  logic [C:0] r;

  assign r   = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, c_in};
  assign s   = r[C-1:0];
  // An empty slot always takes a beat, so bubbles collapse under a stall.
  assign adv = !vld || dn_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      c_out <= 1'b0;
    end else if (adv) begin
      vld   <= up_valid;
      c_out <= r[C];
    end
  end

endmodule

// File: rtl/adder_pipelined.sv
// N-bit add/subtract split into STAGES carry-registered chunks with skew
// registers for pending operand chunks and deskew registers for finished sum chunks.
module adder_pipelined
  import adder_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int C = chunk_w(N, STAGES);

  logic [N-1:0]    y_eff;
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] adv;
  logic [STAGES:0] cy;
  logic            pm_q;

  // Subtract is x + ~y + ~c_in, so c_out reads as "no borrow".
  assign y_eff        = (sub == ADD) ? y : ~y;
  assign cy[0]        = (sub == ADD) ? c_in : ~c_in;
  assign vld_pipe[0]  = in_valid;
  assign adv[STAGES]  = out_ready;
  assign in_ready     = adv[0];
  assign out_valid    = vld_pipe[STAGES];
  assign c_out        = cy[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [N-k*C-1:0]     a_src, b_src;
    logic [C-1:0]         s_k;
    logic [(k+1)*C-1:0]   done_d, done_q;

    if (k == 0) begin : g_head
      assign a_src  = x;
      assign b_src  = y_eff;
      assign done_d = s_k;
    end else begin : g_body
      assign a_src  = g_st[k-1].g_up.a_up;
      assign b_src  = g_st[k-1].g_up.b_up;
      assign done_d = {s_k, g_st[k-1].done_q};
    end

    adder_stage #(.C(C)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (vld_pipe[k]),
      .dn_adv   (adv[k+1]),
      .a        (a_src[C-1:0]),
      .b        (b_src[C-1:0]),
      .c_in     (cy[k]),
      .s        (s_k),
      .c_out    (cy[k+1]),
      .vld      (vld_pipe[k+1]),
      .adv      (adv[k])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      done_q <= '0;
      else if (adv[k]) done_q <= done_d;
    end

    if (k < STAGES-1) begin : g_up
      logic [N-(k+1)*C-1:0] a_up, b_up;
      always_ff @(posedge clk) begin
        if (adv[k]) begin
          a_up <= a_src[N-k*C-1:C];
          b_up <= b_src[N-k*C-1:C];
        end
      end
    end else begin : g_msb
      // Keep a^b at the MSB; with the sum MSB it recovers the carry into bit N-1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pm_q <= 1'b0;
        else if (adv[k]) pm_q <= a_src[C-1] ^ b_src[C-1];
      end
    end
  end

  assign sum      = g_st[STAGES-1].done_q;
  assign overflow = cy[STAGES] ^ pm_q ^ sum[N-1];

endmodule

// File: tb/tb_adder_pipelined.sv
// Bench for adder_pipelined: directed N=8/STAGES=2 scenarios plus a randomized
// sweep over several (N,STAGES) builds against an arithmetic reference model.
module tb_adder_pipelined;

  localparam int NDUT = 5;

  function automatic int cfg_n(input int g);
    case (g)
      0, 1, 2: return 8;
      3:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_s(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 8;
      3:       return 4;
      default: return 8;
    endcase
  endfunction

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NDUT-1:0]            in_valid, in_ready, out_valid, out_ready, c_out, ovf;
  logic [63:0]                x, y;
  logic                       c_in, sub;
  logic [NDUT-1:0][63:0]      sum;
  int                         checks = 0;
  int                         failures = 0;
  logic [65:0]                sbq [NDUT][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int GN = cfg_n(g);
    localparam int GS = cfg_s(g);
    logic [GN-1:0] s_w;
    adder_pipelined #(.N(GN), .STAGES(GS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .x         (x[GN-1:0]),
      .y         (y[GN-1:0]),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (s_w),
      .c_out     (c_out[g]),
      .overflow  (ovf[g])
    );
    assign sum[g] = 64'(s_w);
  end

  // Reference: plain unsigned and signed arithmetic on n-bit values.
  function automatic logic [65:0] model(input int n, input logic [63:0] xa, input logic [63:0] ya,
                                        input logic ci, input logic sb);
    logic [127:0]        ux, uy, mask, r;
    logic signed [127:0] sx, sy, sr, half;
    logic                co, ov;
    mask = (128'd1 << n) - 128'd1;
    half = $signed(128'd1 << (n-1));
    ux = {64'd0, xa} & mask;
    uy = {64'd0, ya} & mask;
    sx = $signed(ux);
    sy = $signed(uy);
    if (ux[n-1]) sx = sx - $signed(128'd1 << n);
    if (uy[n-1]) sy = sy - $signed(128'd1 << n);
    if (!sb) begin
      r  = ux + uy + 128'(ci);
      co = (r >> n) != 0;
      sr = sx + sy + $signed({127'd0, ci});
    end else begin
      r  = ux - uy - 128'(ci);
      co = ux >= (uy + 128'(ci));
      sr = sx - sy - $signed({127'd0, ci});
    end
    ov = (sr >= half) || (sr < -half);
    return {ov, co, 64'(r & mask)};
  endfunction

  // Offer one beat to DUT g with out_ready high; report cycles to out_valid.
  task automatic run_one(input int g, input logic [63:0] xa, input logic [63:0] ya,
                         input logic ci, input logic sb, output int lat, output logic [65:0] got);
    int w;
    lat = -1;
    got = '0;
    @(negedge clk);
    x = xa; y = ya; c_in = ci; sub = sb;
    in_valid = '0;
    in_valid[g] = 1'b1;
    out_ready[g] = 1'b1;
    #1;
    w = 0;
    while (!in_ready[g] && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid[g] = 1'b0;
      #1;
      if (out_valid[g]) begin
        lat = c;
        got = {ovf[g], c_out[g], sum[g]};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = '0;
    x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checks++; if (out_valid[g] !== 1'b0) begin failures++; $display("FAIL reset_out_valid dut=%0d got=%b exp=0", g, out_valid[g]); end
      checks++; if (in_ready[g] !== 1'b1)  begin failures++; $display("FAIL reset_in_ready dut=%0d got=%b exp=1", g, in_ready[g]); end
      checks++; if (sum[g] !== 64'd0)      begin failures++; $display("FAIL reset_sum dut=%0d got=%h exp=0", g, sum[g]); end
      checks++; if (c_out[g] !== 1'b0)     begin failures++; $display("FAIL reset_c_out dut=%0d got=%b exp=0", g, c_out[g]); end
      checks++; if (ovf[g] !== 1'b0)       begin failures++; $display("FAIL reset_overflow dut=%0d got=%b exp=0", g, ovf[g]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat; logic [65:0] got;
    run_one(0, 64'hFF, 64'h01, 1'b0, 1'b0, lat, got);
    checks++; if (lat != 2)            begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (got[7:0] !== 8'h00)  begin failures++; $display("FAIL add_sum got=%h exp=00", got[7:0]); end
    checks++; if (got[64] !== 1'b1)    begin failures++; $display("FAIL add_c_out got=%b exp=1", got[64]); end
    checks++; if (got[65] !== 1'b0)    begin failures++; $display("FAIL add_overflow got=%b exp=0", got[65]); end
  endtask

  task automatic test_sub();
    int lat; logic [65:0] got;
    run_one(0, 64'h80, 64'h01, 1'b0, 1'b1, lat, got);
    checks++; if (got[7:0] !== 8'h7F)  begin failures++; $display("FAIL sub_sum got=%h exp=7f", got[7:0]); end
    checks++; if (got[64] !== 1'b1)    begin failures++; $display("FAIL sub_c_out got=%b exp=1", got[64]); end
    checks++; if (got[65] !== 1'b1)    begin failures++; $display("FAIL sub_overflow got=%b exp=1", got[65]); end
    run_one(0, 64'h00, 64'h01, 1'b0, 1'b1, lat, got);
    checks++; if (got[7:0] !== 8'hFF)  begin failures++; $display("FAIL sub_borrow_sum got=%h exp=ff", got[7:0]); end
    checks++; if (got[64] !== 1'b0)    begin failures++; $display("FAIL sub_borrow_c_out got=%b exp=0", got[64]); end
  endtask

  task automatic test_backpressure();
    int i = 0, j = 0, occ = 0;
    logic [7:0] held = '0;
    logic stalled = 1'b0;
    for (int cyc = 0; cyc < 80 && j < 8; cyc++) begin
      @(negedge clk);
      x = 64'(8'h10 + i); y = 64'd1; c_in = 1'b0; sub = 1'b0;
      in_valid[0]  = (i < 8);
      out_ready[0] = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      checks++;
      if (in_ready[0] !== !(occ == 2 && !out_ready[0])) begin
        failures++; $display("FAIL bp_in_ready cyc=%0d got=%b occ=%0d out_ready=%b", cyc, in_ready[0], occ, out_ready[0]);
      end
      if (stalled) begin
        checks++;
        if (out_valid[0] !== 1'b1 || sum[0][7:0] !== held) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid[0], sum[0][7:0], held);
        end
      end
      if (out_valid[0] && out_ready[0]) begin
        checks++;
        if (sum[0][7:0] !== 8'(8'h11 + j)) begin
          failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", j, sum[0][7:0], 8'(8'h11 + j));
        end
        j++; occ--;
      end
      stalled = out_valid[0] && !out_ready[0];
      held = sum[0][7:0];
      if (in_valid[0] && in_ready[0]) begin i++; occ++; end
    end
    @(negedge clk); in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    checks++; if (j != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", j); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [65:0] q[$]; logic [65:0] exp; int sent = 0, got_n = 0;
    for (int cyc = 0; cyc < 20 && got_n < 6; cyc++) begin
      @(negedge clk);
      in_valid[0] = (sent < 6); out_ready[0] = 1'b1;
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      c_in = 1'($urandom); sub = 1'($urandom);
      #1;
      if (in_valid[0]) begin
        checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, in_ready[0]); end
        q.push_back(model(8, x, y, c_in, sub)); sent++;
      end
      if (out_valid[0]) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL b2b_extra cyc=%0d got=%h exp=none", cyc, sum[0][7:0]); end
        else begin
          exp = q.pop_front();
          if ({ovf[0], c_out[0], sum[0]} !== exp || cyc != got_n + 2) begin
            failures++; $display("FAIL b2b_beat idx=%0d cyc=%0d got=%h exp=%h at cyc %0d", got_n, cyc, {ovf[0], c_out[0], sum[0]}, exp, got_n + 2);
          end
        end
        got_n++;
      end
    end
    @(negedge clk); in_valid[0] = 1'b0;
    checks++; if (got_n != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", got_n); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [65:0] got;
    @(negedge clk);
    x = 64'h33; y = 64'd1; c_in = 1'b0; sub = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(negedge clk); x = 64'h44;
    @(negedge clk); in_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid[0]); end
    checks++; if (in_ready[0] !== 1'b1)  begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready[0]); end
    checks++; if (sum[0] !== 64'd0)      begin failures++; $display("FAIL rstmid_sum got=%h exp=0", sum[0]); end
    @(negedge clk); rst_n = 1'b1; out_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=0", c, out_valid[0]); end
    end
    run_one(0, 64'h21, 64'h05, 1'b0, 1'b0, lat, got);
    checks++; if (lat != 2)           begin failures++; $display("FAIL rstmid_latency got=%0d exp=2", lat); end
    checks++; if (got[7:0] !== 8'h26) begin failures++; $display("FAIL rstmid_sum_new got=%h exp=26", got[7:0]); end
  endtask

  task automatic test_latency();
    int lat; logic [65:0] got, exp; logic [63:0] xa, ya; logic ci, sb;
    for (int g = 0; g < NDUT; g++) begin
      xa = {$urandom, $urandom}; ya = {$urandom, $urandom};
      ci = 1'($urandom); sb = 1'($urandom);
      exp = model(cfg_n(g), xa, ya, ci, sb);
      run_one(g, xa, ya, ci, sb, lat, got);
      checks++; if (lat != cfg_s(g)) begin failures++; $display("FAIL lat_cycles dut=%0d got=%0d exp=%0d", g, lat, cfg_s(g)); end
      checks++; if (got !== exp)     begin failures++; $display("FAIL lat_value dut=%0d got=%h exp=%h", g, got, exp); end
    end
  endtask

  task automatic test_sweep();
    int acc[NDUT]; logic [65:0] exp; logic drain; logic empty;
    for (int g = 0; g < NDUT; g++) begin acc[g] = 0; sbq[g].delete(); end
    drain = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(negedge clk);
      if (cyc >= 25000) drain = 1'b1;
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      c_in = 1'($urandom); sub = 1'($urandom);
      for (int g = 0; g < NDUT; g++) begin
        in_valid[g]  = !drain && acc[g] < 10000 && ($urandom_range(3) != 0);
        out_ready[g] = drain || ($urandom_range(3) != 0);
      end
      #1;
      empty = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
        if (out_valid[g] && out_ready[g]) begin
          checks++;
          if (sbq[g].size() == 0) begin failures++; $display("FAIL sweep_extra dut=%0d got=%h exp=none", g, sum[g]); end
          else begin
            exp = sbq[g].pop_front();
            if ({ovf[g], c_out[g], sum[g]} !== exp) begin
              failures++; $display("FAIL sweep_beat dut=%0d got=%h exp=%h", g, {ovf[g], c_out[g], sum[g]}, exp);
            end
          end
        end
        if (in_valid[g] && in_ready[g]) begin
          sbq[g].push_back(model(cfg_n(g), x, y, c_in, sub));
          acc[g]++;
        end
        if (acc[g] < 10000 || sbq[g].size() != 0) empty = 1'b0;
      end
      if (empty) break;
    end
    @(negedge clk); in_valid = '0;
    for (int g = 0; g < NDUT; g++) begin
      checks++; if (acc[g] < 10000)      begin failures++; $display("FAIL sweep_accepted dut=%0d got=%0d exp=10000", g, acc[g]); end
      checks++; if (sbq[g].size() != 0)  begin failures++; $display("FAIL sweep_drain dut=%0d left=%0d exp=0", g, sbq[g].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_latency();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
